riscv_cmd_streamer_param: RTL and testbench
===========================================

# riscv_cmd_streamer_param

Parametrised command streamer that holds a small program/command memory and presents its words to a downstream RISC-V core or accelerator over a valid/ready stream. Generalises the fixed single-shot streamer: configurable word width and depth, runtime base/length window with address wrap, one-shot or loop mode, graceful stop, and a transfer counter. Sits between the host loader interface and the core's command input.

## Interface
- DATA_W, 32, command word width
- DEPTH, 64, memory depth in words (power of two)
- ADDR_W, 6, address width, must equal log2(DEPTH)
- CNT_W, 16, width of the transfer counter
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- load_we  in  1  memory write strobe (honoured only when busy=0)
- load_addr  in  ADDR_W  memory write address
- load_data  in  DATA_W  memory write data
- start  in  1  begin streaming (sampled only in IDLE)
- base_addr  in  ADDR_W  first word address, sampled with start
- length  in  ADDR_W+1  words per pass (1..DEPTH), sampled with start
- loop_mode  in  1  1 = repeat window until stop; sampled with start
- stop  in  1  request graceful termination
- cmd_valid  out  1  cmd_data valid
- cmd_data  out  DATA_W  current command word
- cmd_last  out  1  current word is last of a pass
- cmd_ready  in  1  downstream accepts word
- busy  out  1  high in STREAM
- done  out  1  one-cycle pulse on completion
- xfer_count  out  CNT_W  words accepted since last start

## Operation
- States: IDLE, STREAM, DONE. Reset -> IDLE; cmd_valid, cmd_last, busy, done = 0; cmd_data = 0; xfer_count = 0; stop_pending = 0. Memory contents are not reset.
- IDLE: load_we writes mem[load_addr]. start with length in 1..DEPTH: latch base/length/loop_mode, clear xfer_count, load cmd_data = mem[base_addr], cmd_last = (length==1), cmd_valid = 1, -> STREAM. start with length 0 or length > DEPTH: ignored, stays IDLE.
- STREAM: cmd_data/cmd_valid/cmd_last held stable while cmd_ready=0 (valid never withdrawn without handshake). On handshake: xfer_count += 1 (wraps modulo 2^CNT_W); pointer advances (ptr+1) mod DEPTH and next word registered in the same edge, giving one word per cycle under continuous ready.
- End of pass (handshake with cmd_last=1): loop_mode=0 or stop_pending -> cmd_valid=0, -> DONE. loop_mode=1 -> pointer reloads base, streaming continues without a bubble.
- stop: in STREAM sets stop_pending; the current presented word still completes; at its handshake cmd_valid drops and FSM -> DONE regardless of cmd_last. stop and handshake in the same cycle: that word is the final one. stop outside STREAM ignored.
- DONE: done=1 for exactly one cycle, stop_pending cleared, -> IDLE. xfer_count holds until next accepted start.
- load_we while busy: ignored, memory unchanged. start while busy: ignored.
- reset in any state, including mid-handshake: next cycle is IDLE with reset values; no done pulse.

## Timing
- start sampled at edge N -> cmd_valid=1 with word at base visible after edge N (latency 1).
- Throughput: 1 word/cycle with cmd_ready held high.
- Last handshake at edge M -> cmd_valid=0 and done=1 after M; IDLE after M+1; new start accepted at M+2.
- Memory write at edge K is visible to a start sampled at edge K+1 or later.
- Address wrap: base+i computed modulo DEPTH (e.g. base=62, length=4 -> 62,63,0,1).

## Test plan
- Load mem[i]=0x100+i, start base=0 length=4 one-shot, cmd_ready=1 -> words 0x100..0x103 on 4 consecutive cycles, cmd_last on 0x103, done one cycle later, xfer_count=4.
- base=62 length=4, cmd_ready toggling 1,0,1,0 -> order 0x13E,0x13F,0x100,0x101; data held stable while ready=0; xfer_count=4.
- loop_mode=1 base=5 length=3, ready=1, stop asserted on 8th cycle of streaming -> sequence 5,6,7,5,6,7,5,6 then done; xfer_count=8.
- start with length=0, and start while busy, and load_we while busy -> no state change, memory unchanged, no extra output.
- reset asserted mid-stream with cmd_valid=1 -> next cycle cmd_valid=0, busy=0, done=0, xfer_count=0; fresh start streams correctly.
- length=1 one-shot with ready low 3 cycles -> single word held 3 cycles with cmd_last=1, accepted on 4th, done next cycle.

Source files
------------

// File: rtl/riscv_cmd_streamer_param.sv
// Parametrised command streamer: presents a base/length window of a local command
// memory on a valid/ready stream, one-shot or looping, with graceful stop.
module riscv_cmd_streamer_param #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_we,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    input  logic              loop_mode,
    input  logic              stop,
    output logic              cmd_valid,
    output logic [DATA_W-1:0] cmd_data,
    output logic              cmd_last,
    input  logic              cmd_ready,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  xfer_count
);

    typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

    localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W+1)'(DEPTH);

    state_t             state_q;
    logic [DATA_W-1:0]  mem_q [DEPTH];
    logic [ADDR_W-1:0]  ptr_q;
    logic [ADDR_W-1:0]  base_q;
    logic [ADDR_W:0]    len_q;
    logic [ADDR_W:0]    idx_q;
    logic               loop_q;
    logic               stop_pending_q;
    logic               cmd_valid_q;
    logic               cmd_last_q;
    logic [DATA_W-1:0]  cmd_data_q;
    logic               busy_q;
    logic               done_q;
    logic [CNT_W-1:0]   xfer_count_q;

    logic               handshake;
    logic               start_ok;
    logic               finish_d;
    logic [ADDR_W-1:0]  ptr_d;
    logic [ADDR_W:0]    idx_d;
    logic               last_d;

    // idx_q is the 1-based position of the presented word within the current pass
    always_comb begin
        handshake = cmd_valid_q && cmd_ready;
        start_ok  = start && (length != '0) && (length <= LEN_MAX);
        finish_d  = (cmd_last_q && !loop_q) || stop_pending_q || stop;
        ptr_d     = ptr_q + 1'b1;
        idx_d     = idx_q + 1'b1;
        if (cmd_last_q) begin
            ptr_d = base_q;
            idx_d = (ADDR_W+1)'(1);
        end
        last_d = (idx_d == len_q);
    end

    always_ff @(posedge clk) begin
        if (load_we && !busy_q) begin
            mem_q[load_addr] <= load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            ptr_q          <= '0;
            base_q         <= '0;
            len_q          <= '0;
            idx_q          <= '0;
            loop_q         <= 1'b0;
            stop_pending_q <= 1'b0;
            cmd_valid_q    <= 1'b0;
            cmd_last_q     <= 1'b0;
            cmd_data_q     <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            xfer_count_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_ok) begin
                        base_q       <= base_addr;
                        len_q        <= length;
                        loop_q       <= loop_mode;
                        ptr_q        <= base_addr;
                        idx_q        <= (ADDR_W+1)'(1);
                        xfer_count_q <= '0;
                        cmd_data_q   <= mem_q[base_addr];
                        cmd_last_q   <= (length == (ADDR_W+1)'(1));
                        cmd_valid_q  <= 1'b1;
                        busy_q       <= 1'b1;
                        state_q      <= STREAM;
                    end
                end
                STREAM: begin
                    if (handshake) begin
                        xfer_count_q <= xfer_count_q + 1'b1;
                        if (finish_d) begin
                            cmd_valid_q <= 1'b0;
                            cmd_last_q  <= 1'b0;
                            busy_q      <= 1'b0;
                            done_q      <= 1'b1;
                            state_q     <= DONE;
                        end else begin
                            ptr_q      <= ptr_d;
                            idx_q      <= idx_d;
                            cmd_data_q <= mem_q[ptr_d];
                            cmd_last_q <= last_d;
                        end
                    end else if (stop) begin
                        stop_pending_q <= 1'b1;
                    end
                end
                DONE: begin
                    done_q         <= 1'b0;
                    stop_pending_q <= 1'b0;
                    state_q        <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cmd_valid  = cmd_valid_q;
    assign cmd_data   = cmd_data_q;
    assign cmd_last   = cmd_last_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign xfer_count = xfer_count_q;

endmodule

// File: tb/tb_riscv_cmd_streamer_param.sv
// Directed testbench for riscv_cmd_streamer_param: one-shot, wrap, loop+stop,
// ignored commands, mid-stream reset and single-word backpressure.
module tb_riscv_cmd_streamer_param;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_we;
    logic [5:0]  load_addr;
    logic [31:0] load_data;
    logic        start;
    logic [5:0]  base_addr;
    logic [6:0]  length;
    logic        loop_mode;
    logic        stop;
    logic        cmd_valid;
    logic [31:0] cmd_data;
    logic        cmd_last;
    logic        cmd_ready;
    logic        busy;
    logic        done;
    logic [15:0] xfer_count;

    int errors = 0;
    int checks = 0;

    riscv_cmd_streamer_param dut (
        .clk       (clk),
        .reset     (reset),
        .load_we   (load_we),
        .load_addr (load_addr),
        .load_data (load_data),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .loop_mode (loop_mode),
        .stop      (stop),
        .cmd_valid (cmd_valid),
        .cmd_data  (cmd_data),
        .cmd_last  (cmd_last),
        .cmd_ready (cmd_ready),
        .busy      (busy),
        .done      (done),
        .xfer_count(xfer_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Drive a start request for one edge, then drop start.
    task automatic applyStimulus(input logic [5:0] base, input logic [6:0] len, input logic lp);
        start     = 1'b1;
        base_addr = base;
        length    = len;
        loop_mode = lp;
        tick();
        start     = 1'b0;
    endtask

    task automatic checkWord(input string tag, input logic v, input logic [31:0] d, input logic l);
        checkOutput({tag, "_valid"}, 32'(cmd_valid), 32'(v));
        if (v) begin
            checkOutput({tag, "_data"}, cmd_data, d);
            checkOutput({tag, "_last"}, 32'(cmd_last), 32'(l));
        end
    endtask

    initial begin
        reset = 1'b1; load_we = 1'b0; load_addr = '0; load_data = '0;
        start = 1'b0; base_addr = '0; length = '0; loop_mode = 1'b0;
        stop = 1'b0; cmd_ready = 1'b0;
        tick(); tick();
        reset = 1'b0;
        checkOutput("rst_valid", 32'(cmd_valid), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_last", 32'(cmd_last), 32'd0);
        checkOutput("rst_data", cmd_data, 32'd0);
        checkOutput("rst_xfer", 32'(xfer_count), 32'd0);

        for (int i = 0; i < 64; i++) begin
            load_we = 1'b1; load_addr = 6'(i); load_data = 32'h100 + 32'(i);
            tick();
        end
        load_we = 1'b0;

        // one-shot base 0 length 4 under continuous ready
        cmd_ready = 1'b1;
        applyStimulus(6'd0, 7'd4, 1'b0);
        checkOutput("t1_busy", 32'(busy), 32'd1);
        checkWord("t1_w0", 1'b1, 32'h100, 1'b0);
        for (int k = 1; k < 4; k++) begin
            tick();
            checkWord("t1_wk", 1'b1, 32'h100 + 32'(k), k == 3);
        end
        tick();
        checkWord("t1_end", 1'b0, 32'h0, 1'b0);
        checkOutput("t1_done", 32'(done), 32'd1);
        checkOutput("t1_busy_end", 32'(busy), 32'd0);
        checkOutput("t1_xfer", 32'(xfer_count), 32'd4);
        tick();
        checkOutput("t1_done_pulse", 32'(done), 32'd0);
        checkOutput("t1_xfer_hold", 32'(xfer_count), 32'd4);

        // wrap base 62 length 4 with ready toggling
        applyStimulus(6'd62, 7'd4, 1'b0);
        checkWord("t2_w0", 1'b1, 32'h13E, 1'b0);
        cmd_ready = 1'b1; tick(); checkWord("t2_w1", 1'b1, 32'h13F, 1'b0);
        cmd_ready = 1'b0; tick(); checkWord("t2_h1", 1'b1, 32'h13F, 1'b0);
        cmd_ready = 1'b1; tick(); checkWord("t2_w2", 1'b1, 32'h100, 1'b0);
        cmd_ready = 1'b0; tick(); checkWord("t2_h2", 1'b1, 32'h100, 1'b0);
        cmd_ready = 1'b1; tick(); checkWord("t2_w3", 1'b1, 32'h101, 1'b1);
        cmd_ready = 1'b0; tick(); checkWord("t2_h3", 1'b1, 32'h101, 1'b1);
        checkOutput("t2_xfer_mid", 32'(xfer_count), 32'd3);
        cmd_ready = 1'b1; tick();
        checkWord("t2_end", 1'b0, 32'h0, 1'b0);
        checkOutput("t2_done", 32'(done), 32'd1);
        checkOutput("t2_xfer", 32'(xfer_count), 32'd4);
        tick();

        // loop base 5 length 3, stop during the 8th presented word
        applyStimulus(6'd5, 7'd3, 1'b1);
        for (int k = 0; k < 8; k++) begin
            checkWord("t3_w", 1'b1, 32'h105 + 32'(k % 3), (k % 3) == 2);
            if (k == 7) stop = 1'b1;
            tick();
            stop = 1'b0;
        end
        checkWord("t3_end", 1'b0, 32'h0, 1'b0);
        checkOutput("t3_done", 32'(done), 32'd1);
        checkOutput("t3_xfer", 32'(xfer_count), 32'd8);
        tick();
        checkOutput("t3_idle_done", 32'(done), 32'd0);

        // illegal lengths are ignored
        applyStimulus(6'd3, 7'd0, 1'b0);
        checkOutput("t4_len0_busy", 32'(busy), 32'd0);
        checkOutput("t4_len0_valid", 32'(cmd_valid), 32'd0);
        applyStimulus(6'd3, 7'd65, 1'b0);
        checkOutput("t4_len65_busy", 32'(busy), 32'd0);
        checkOutput("t4_len65_xfer", 32'(xfer_count), 32'd8);
        stop = 1'b1; tick(); stop = 1'b0;
        checkOutput("t4_stop_idle", 32'(busy), 32'd0);

        // start and load while busy are ignored
        cmd_ready = 1'b0;
        applyStimulus(6'd10, 7'd2, 1'b0);
        checkWord("t4_w0", 1'b1, 32'h10A, 1'b0);
        load_we = 1'b1; load_addr = 6'd10; load_data = 32'hDEAD;
        applyStimulus(6'd0, 7'd1, 1'b0);
        load_we = 1'b0;
        checkWord("t4_busy_hold", 1'b1, 32'h10A, 1'b0);
        checkOutput("t4_busy_xfer", 32'(xfer_count), 32'd0);
        cmd_ready = 1'b1; tick();
        checkWord("t4_w1", 1'b1, 32'h10B, 1'b1);
        tick();
        checkOutput("t4_done", 32'(done), 32'd1);
        checkOutput("t4_xfer", 32'(xfer_count), 32'd2);
        tick();
        applyStimulus(6'd10, 7'd1, 1'b0);
        checkWord("t4_mem_kept", 1'b1, 32'h10A, 1'b1);
        tick(); tick();

        // reset mid-stream
        applyStimulus(6'd20, 7'd8, 1'b0);
        tick(); tick();
        checkWord("t5_pre", 1'b1, 32'h116, 1'b0);
        reset = 1'b1; tick(); reset = 1'b0;
        checkOutput("t5_valid", 32'(cmd_valid), 32'd0);
        checkOutput("t5_busy", 32'(busy), 32'd0);
        checkOutput("t5_done", 32'(done), 32'd0);
        checkOutput("t5_xfer", 32'(xfer_count), 32'd0);
        applyStimulus(6'd0, 7'd2, 1'b0);
        checkWord("t5_w0", 1'b1, 32'h100, 1'b0);
        tick();
        checkWord("t5_w1", 1'b1, 32'h101, 1'b1);
        tick();
        checkOutput("t5_done_end", 32'(done), 32'd1);
        checkOutput("t5_xfer_end", 32'(xfer_count), 32'd2);
        tick();

        // single word with three cycles of backpressure
        cmd_ready = 1'b0;
        applyStimulus(6'd40, 7'd1, 1'b0);
        checkWord("t6_c1", 1'b1, 32'h128, 1'b1);
        tick(); checkWord("t6_c2", 1'b1, 32'h128, 1'b1);
        tick(); checkWord("t6_c3", 1'b1, 32'h128, 1'b1);
        checkOutput("t6_done_early", 32'(done), 32'd0);
        cmd_ready = 1'b1; tick();
        checkWord("t6_end", 1'b0, 32'h0, 1'b0);
        checkOutput("t6_done", 32'(done), 32'd1);
        checkOutput("t6_xfer", 32'(xfer_count), 32'd1);
        tick();
        checkOutput("t6_done_pulse", 32'(done), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
